control_sequencer: RTL and testbench
====================================

# control_sequencer

Hardwired control unit that drives the existing `Datapath` through its fetch and execute T-states. It replaces hand-scripted bench sequencing. It decodes the opcode field of the IR and emits one-hot register enables, bus-drive selects, the ALU `CONTROL` code and a memory read strobe, one T-state per clock. It waits on a memory-ready handshake during instruction read and halts on a HALT opcode or an external stop.

## Interface
- `OP_ADD`, 5'b00011: opcode, R[ra] = R[rb] + R[rc]
- `OP_SUB`, 5'b00100: opcode, R[ra] = R[rb] - R[rc]
- `OP_MFHI`, 5'b10111: opcode, R[ra] = HI
- `OP_MFLO`, 5'b11000: opcode, R[ra] = LO
- `OP_NOP`, 5'b11010: opcode, no operation
- `OP_HALT`, 5'b11011: opcode, stop sequencing
- `ALU_ADD`, 5'b00011: `CONTROL` code for add
- `ALU_SUB`, 5'b00100: `CONTROL` code for subtract
- `Clock`  in  1  rising-edge clock
- `Clear`  in  1  synchronous active-high reset
- `IR_Op`  in  5  IR[31:27] from datapath
- `Mem_Ready`  in  1  memory read data valid this cycle
- `Stop`  in  1  request halt at the next instruction boundary
- `PC_Out`, `MDR_Out`, `HI_Out`, `LO_Out`, `ZLow_Out`, `R_Out`  out  1 each  bus drive selects
- `PC_In`, `MAR_In`, `MDR_In`, `IR_In`, `Y_In`, `Z_In`, `R_In`  out  1 each  register load enables
- `G_RA`, `G_RB`, `G_RC`  out  1 each  register-field select for `R_In`/`R_Out`
- `IncPC`, `Read`  out  1 each  PC increment; memory read
- `CONTROL`  out  5  ALU operation code, 0 when idle
- `Run`  out  1  high while sequencing
- `Illegal`  out  1  one-cycle pulse on an unrecognised opcode
- `Instr_Count`  out  16  completed-instruction counter

## Operation
- States: RESET, T0, T1, T2, T3, T4, T5, HALT.
- All outputs decode combinationally from state, plus `IR_Op` in T3–T5. Outputs not listed for a state are 0.
- RESET: `Run`=0. Next state is T0.
- T0: `PC_Out`, `MAR_In`, `IncPC`. Next state is T1.
- T1: `Read`, `MDR_In`. Hold in T1 while `Mem_Ready`=0. Go to T2 in the cycle after `Mem_Ready`=1 is sampled.
- T2: `MDR_Out`, `IR_In`. Next state is T3.
- T3, by `IR_Op`:
  - ADD/SUB: `G_RB`, `R_Out`, `Y_In`; next state T4.
  - MFHI: `HI_Out`, `G_RA`, `R_In`; instruction ends.
  - MFLO: `LO_Out`, `G_RA`, `R_In`; instruction ends.
  - NOP: no outputs; instruction ends.
  - HALT: next state HALT; the counter still increments.
  - Any other opcode: `Illegal`=1; treated as NOP.
- T4 (ADD/SUB only): `G_RC`, `R_Out`, `Z_In`, and `CONTROL` = `ALU_ADD` or `ALU_SUB`. Next state T5.
- T5: `ZLow_Out`, `G_RA`, `R_In`. Instruction ends.
- Instruction end: `Instr_Count` += 1 (wraps 0xFFFF→0x0000). Next state is HALT if `Stop`=1 in that cycle, otherwise T0.
- `Stop` is ignored outside end-of-instruction cycles. It is not latched.
- HALT: `Run`=0. All strobes stay 0 until `Clear`.
- `Run`=1 in T0–T5.

## Timing
- `Clear` high at a rising edge forces state RESET and `Instr_Count`=0 on that edge, from any state including mid-T1 wait or mid-execute.
- After reset, every output is 0 (`CONTROL`=0, `Run`=0, `Illegal`=0) until the edge following `Clear` deassertion.
- Latency with `Mem_Ready` high in the first T1 cycle:
  - MFHI, MFLO, NOP, illegal: 4 cycles
  - ADD, SUB: 6 cycles
  - Each cycle of `Mem_Ready` low in T1 adds one cycle.
- `IR_Op` is sampled only in T3–T5. The IR loads on the T2→T3 edge.
- `IncPC` is high for exactly one cycle per instruction.
- `Read`/`MDR_In` stay high for the whole T1 dwell. `MDR_In` is never high outside T1.
- Simultaneous HALT opcode and `Stop`: enter HALT; counter increments once.
- `Instr_Count` updates on the edge that leaves the final execute state.

## Test plan
- MFHI: `Clear` 1 cycle, `Mem_Ready`=1, `IR_Op`=5'b10111 → states RESET,T0,T1,T2,T3,T0; T3 shows `HI_Out`=`G_RA`=`R_In`=1; `Instr_Count`=1 after the T3 edge.
- ADD with 2 wait cycles: `Mem_Ready` low 2 cycles, `IR_Op`=5'b00011 → T1 lasts 3 cycles with `Read`=1; T4 shows `CONTROL`=5'b00011 and `Z_In`=1; T5 shows `ZLow_Out`, `R_In`; 8 cycles T0→next T0.
- SUB then HALT: `IR_Op`=5'b00100 then 5'b11011 → T4 `CONTROL`=5'b00100; then HALT with `Run`=0, no `IncPC` for 10 cycles; `Instr_Count`=2.
- Stop and illegal: `Stop` pulsed in T2 then in MFLO's T3; also `IR_Op`=5'b11111 → T2 pulse ignored; T3 pulse enters HALT; opcode 5'b11111 gives a 1-cycle `Illegal` and returns to T0.
- Reset mid-op: `Clear` asserted during ADD T4 → next cycle RESET, all outputs 0, `Instr_Count`=0, then T0.
- Counter wrap: preload via 65535 NOPs (or force) → next completion gives `Instr_Count`=0x0000.

Source files
------------

// File: rtl/control_sequencer.sv
// Hardwired control unit for the Datapath: walks the fetch/execute T-states,
// decodes IR_Op into one-hot strobes and counts completed instructions.
module control_sequencer (
    input  logic        Clock,
    input  logic        Clear,
    input  logic [4:0]  IR_Op,
    input  logic        Mem_Ready,
    input  logic        Stop,
    output logic        PC_Out,
    output logic        MDR_Out,
    output logic        HI_Out,
    output logic        LO_Out,
    output logic        ZLow_Out,
    output logic        R_Out,
    output logic        PC_In,
    output logic        MAR_In,
    output logic        MDR_In,
    output logic        IR_In,
    output logic        Y_In,
    output logic        Z_In,
    output logic        R_In,
    output logic        G_RA,
    output logic        G_RB,
    output logic        G_RC,
    output logic        IncPC,
    output logic        Read,
    output logic [4:0]  CONTROL,
    output logic        Run,
    output logic        Illegal,
    output logic [15:0] Instr_Count
);

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_MFHI = 5'b10111;
    localparam logic [4:0] OP_MFLO = 5'b11000;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;
    localparam logic [4:0] ALU_ADD = 5'b00011;
    localparam logic [4:0] ALU_SUB = 5'b00100;

    typedef enum logic [2:0] {
        ST_RESET = 3'd0,
        ST_T0    = 3'd1,
        ST_T1    = 3'd2,
        ST_T2    = 3'd3,
        ST_T3    = 3'd4,
        ST_T4    = 3'd5,
        ST_T5    = 3'd6,
        ST_HALT  = 3'd7
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [15:0] instr_count_q;
    logic [15:0] instr_count_d;
    logic        instr_end_s;
    logic        halt_op_s;

    // Next-state sequencing and end-of-instruction bookkeeping.
    always_comb begin
        state_d       = state_q;
        instr_count_d = instr_count_q;
        instr_end_s   = 1'b0;
        halt_op_s     = 1'b0;
        case (state_q)
            ST_RESET: state_d = ST_T0;
            ST_T0:    state_d = ST_T1;
            ST_T1: begin
                if (Mem_Ready) begin
                    state_d = ST_T2;
                end else begin
                    state_d = ST_T1;
                end
            end
            ST_T2:    state_d = ST_T3;
            ST_T3: begin
                case (IR_Op)
                    OP_ADD, OP_SUB: state_d = ST_T4;
                    OP_HALT: begin
                        halt_op_s   = 1'b1;
                        instr_end_s = 1'b1;
                    end
                    default: instr_end_s = 1'b1;
                endcase
            end
            ST_T4:    state_d = ST_T5;
            ST_T5:    instr_end_s = 1'b1;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_RESET;
        endcase
        // Stop is honoured only on the instruction boundary and never latched.
        if (instr_end_s) begin
            instr_count_d = instr_count_q + 16'd1;
            if (halt_op_s || Stop) begin
                state_d = ST_HALT;
            end else begin
                state_d = ST_T0;
            end
        end else begin
            instr_count_d = instr_count_q;
        end
    end

    // State and instruction counter flops with synchronous Clear.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            state_q       <= ST_RESET;
            instr_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign Instr_Count = instr_count_q;

    // Strobe decode from the current T-state and, during execute, the opcode.
    always_comb begin
        PC_Out   = 1'b0;
        MDR_Out  = 1'b0;
        HI_Out   = 1'b0;
        LO_Out   = 1'b0;
        ZLow_Out = 1'b0;
        R_Out    = 1'b0;
        PC_In    = 1'b0;
        MAR_In   = 1'b0;
        MDR_In   = 1'b0;
        IR_In    = 1'b0;
        Y_In     = 1'b0;
        Z_In     = 1'b0;
        R_In     = 1'b0;
        G_RA     = 1'b0;
        G_RB     = 1'b0;
        G_RC     = 1'b0;
        IncPC    = 1'b0;
        Read     = 1'b0;
        CONTROL  = 5'd0;
        Run      = 1'b0;
        Illegal  = 1'b0;
        case (state_q)
            ST_T0: begin
                Run    = 1'b1;
                PC_Out = 1'b1;
                MAR_In = 1'b1;
                IncPC  = 1'b1;
            end
            ST_T1: begin
                Run    = 1'b1;
                Read   = 1'b1;
                MDR_In = 1'b1;
            end
            ST_T2: begin
                Run     = 1'b1;
                MDR_Out = 1'b1;
                IR_In   = 1'b1;
            end
            ST_T3: begin
                Run = 1'b1;
                case (IR_Op)
                    OP_ADD, OP_SUB: begin
                        G_RB  = 1'b1;
                        R_Out = 1'b1;
                        Y_In  = 1'b1;
                    end
                    OP_MFHI: begin
                        HI_Out = 1'b1;
                        G_RA   = 1'b1;
                        R_In   = 1'b1;
                    end
                    OP_MFLO: begin
                        LO_Out = 1'b1;
                        G_RA   = 1'b1;
                        R_In   = 1'b1;
                    end
                    OP_NOP, OP_HALT: Illegal = 1'b0;
                    default: Illegal = 1'b1;
                endcase
            end
            ST_T4: begin
                Run   = 1'b1;
                G_RC  = 1'b1;
                R_Out = 1'b1;
                Z_In  = 1'b1;
                case (IR_Op)
                    OP_ADD:  CONTROL = ALU_ADD;
                    OP_SUB:  CONTROL = ALU_SUB;
                    default: CONTROL = 5'd0;
                endcase
            end
            ST_T5: begin
                Run      = 1'b1;
                ZLow_Out = 1'b1;
                G_RA     = 1'b1;
                R_In     = 1'b1;
            end
            default: Run = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: the driver queues per-cycle expected
// strobe vectors and counts; a negedge monitor pops and compares them.
module tb_control_sequencer;

    logic        clk;
    logic        Clear;
    logic [4:0]  IR_Op;
    logic        Mem_Ready;
    logic        Stop;
    logic        PC_Out, MDR_Out, HI_Out, LO_Out, ZLow_Out, R_Out;
    logic        PC_In, MAR_In, MDR_In, IR_In, Y_In, Z_In, R_In;
    logic        G_RA, G_RB, G_RC, IncPC, Read, Run, Illegal;
    logic [4:0]  CONTROL;
    logic [15:0] Instr_Count;

    control_sequencer dut (
        .Clock(clk), .Clear(Clear), .IR_Op(IR_Op), .Mem_Ready(Mem_Ready), .Stop(Stop),
        .PC_Out(PC_Out), .MDR_Out(MDR_Out), .HI_Out(HI_Out), .LO_Out(LO_Out),
        .ZLow_Out(ZLow_Out), .R_Out(R_Out), .PC_In(PC_In), .MAR_In(MAR_In),
        .MDR_In(MDR_In), .IR_In(IR_In), .Y_In(Y_In), .Z_In(Z_In), .R_In(R_In),
        .G_RA(G_RA), .G_RB(G_RB), .G_RC(G_RC), .IncPC(IncPC), .Read(Read),
        .CONTROL(CONTROL), .Run(Run), .Illegal(Illegal), .Instr_Count(Instr_Count)
    );

    localparam logic [24:0] B_PC_OUT   = 25'h1 << 24;
    localparam logic [24:0] B_MDR_OUT  = 25'h1 << 23;
    localparam logic [24:0] B_HI_OUT   = 25'h1 << 22;
    localparam logic [24:0] B_LO_OUT   = 25'h1 << 21;
    localparam logic [24:0] B_ZLOW_OUT = 25'h1 << 20;
    localparam logic [24:0] B_R_OUT    = 25'h1 << 19;
    localparam logic [24:0] B_MAR_IN   = 25'h1 << 17;
    localparam logic [24:0] B_MDR_IN   = 25'h1 << 16;
    localparam logic [24:0] B_IR_IN    = 25'h1 << 15;
    localparam logic [24:0] B_Y_IN     = 25'h1 << 14;
    localparam logic [24:0] B_Z_IN     = 25'h1 << 13;
    localparam logic [24:0] B_R_IN     = 25'h1 << 12;
    localparam logic [24:0] B_G_RA     = 25'h1 << 11;
    localparam logic [24:0] B_G_RB     = 25'h1 << 10;
    localparam logic [24:0] B_G_RC     = 25'h1 << 9;
    localparam logic [24:0] B_INCPC    = 25'h1 << 8;
    localparam logic [24:0] B_READ     = 25'h1 << 7;
    localparam logic [24:0] B_RUN      = 25'h1 << 1;
    localparam logic [24:0] B_ILLEGAL  = 25'h1;

    localparam logic [24:0] E_ZERO   = 25'h0;
    localparam logic [24:0] E_T0     = B_PC_OUT | B_MAR_IN | B_INCPC | B_RUN;
    localparam logic [24:0] E_T1     = B_READ | B_MDR_IN | B_RUN;
    localparam logic [24:0] E_T2     = B_MDR_OUT | B_IR_IN | B_RUN;
    localparam logic [24:0] E_T3_AS  = B_G_RB | B_R_OUT | B_Y_IN | B_RUN;
    localparam logic [24:0] E_T3_HI  = B_HI_OUT | B_G_RA | B_R_IN | B_RUN;
    localparam logic [24:0] E_T3_LO  = B_LO_OUT | B_G_RA | B_R_IN | B_RUN;
    localparam logic [24:0] E_T3_NOP = B_RUN;
    localparam logic [24:0] E_T3_ILL = B_RUN | B_ILLEGAL;
    localparam logic [24:0] E_T4_ADD = B_G_RC | B_R_OUT | B_Z_IN | B_RUN | (25'd3 << 2);
    localparam logic [24:0] E_T4_SUB = B_G_RC | B_R_OUT | B_Z_IN | B_RUN | (25'd4 << 2);
    localparam logic [24:0] E_T5     = B_ZLOW_OUT | B_G_RA | B_R_IN | B_RUN;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_MFHI = 5'b10111;
    localparam logic [4:0] OP_MFLO = 5'b11000;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;
    localparam logic [4:0] OP_BAD  = 5'b11111;

    typedef struct {
        int          cyc;
        string       name;
        logic [24:0] sig;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          done = 1'b0;
    bit          done_chk = 1'b0;
    logic [24:0] act_s;

    assign act_s = {PC_Out, MDR_Out, HI_Out, LO_Out, ZLow_Out, R_Out, PC_In, MAR_In,
                    MDR_In, IR_In, Y_In, Z_In, R_In, G_RA, G_RB, G_RC, IncPC, Read,
                    CONTROL, Run, Illegal};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare the queued expectation for this cycle against the DUT.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks = checks + 1;
            if (e.cyc != cyc || act_s !== e.sig || Instr_Count !== e.cnt) begin
                errors = errors + 1;
                $display("FAIL %s cyc=%0d: got sig=%h cnt=%h, expected sig=%h cnt=%h (cyc %0d)",
                         e.name, cyc, act_s, Instr_Count, e.sig, e.cnt, e.cyc);
            end
        end else if (done && !done_chk) begin
            done_chk = 1'b1;
            checks = checks + 1;
            if (sb.size() != 0) begin
                errors = errors + 1;
                $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
            end
        end
    end

    task automatic step(input logic clr, input logic mr, input logic stp,
                        input logic [4:0] op, input bit chk,
                        input logic [24:0] es, input logic [15:0] ec, input string nm);
        exp_t e;
        Clear = clr;
        Mem_Ready = mr;
        Stop = stp;
        IR_Op = op;
        if (chk) begin
            e.cyc = cyc;
            e.name = nm;
            e.sig = es;
            e.cnt = ec;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        Clear = 1'b1; Mem_Ready = 1'b0; Stop = 1'b0; IR_Op = 5'd0;
        // MFHI after a one-cycle Clear
        step(1'b1, 1'b1, 1'b0, OP_MFHI, 1'b0, E_ZERO, 16'd0, "clear0");
        step(1'b0, 1'b1, 1'b0, OP_MFHI, 1'b1, E_ZERO,   16'd0, "reset_state");
        step(1'b0, 1'b1, 1'b0, OP_MFHI, 1'b1, E_T0,     16'd0, "mfhi_t0");
        step(1'b0, 1'b1, 1'b0, OP_MFHI, 1'b1, E_T1,     16'd0, "mfhi_t1");
        step(1'b0, 1'b1, 1'b0, OP_MFHI, 1'b1, E_T2,     16'd0, "mfhi_t2");
        step(1'b0, 1'b1, 1'b0, OP_MFHI, 1'b1, E_T3_HI,  16'd0, "mfhi_t3");
        // ADD with two wait cycles in T1
        step(1'b0, 1'b0, 1'b0, OP_ADD,  1'b1, E_T0,     16'd1, "add_t0");
        step(1'b0, 1'b0, 1'b0, OP_ADD,  1'b1, E_T1,     16'd1, "add_t1_w1");
        step(1'b0, 1'b0, 1'b0, OP_ADD,  1'b1, E_T1,     16'd1, "add_t1_w2");
        step(1'b0, 1'b1, 1'b0, OP_ADD,  1'b1, E_T1,     16'd1, "add_t1_rdy");
        step(1'b0, 1'b1, 1'b0, OP_ADD,  1'b1, E_T2,     16'd1, "add_t2");
        step(1'b0, 1'b1, 1'b0, OP_ADD,  1'b1, E_T3_AS,  16'd1, "add_t3");
        step(1'b0, 1'b1, 1'b0, OP_ADD,  1'b1, E_T4_ADD, 16'd1, "add_t4");
        step(1'b0, 1'b1, 1'b0, OP_ADD,  1'b1, E_T5,     16'd1, "add_t5");
        // SUB then HALT opcode
        step(1'b0, 1'b1, 1'b0, OP_SUB,  1'b1, E_T0,     16'd2, "sub_t0");
        step(1'b0, 1'b1, 1'b0, OP_SUB,  1'b1, E_T1,     16'd2, "sub_t1");
        step(1'b0, 1'b1, 1'b0, OP_SUB,  1'b1, E_T2,     16'd2, "sub_t2");
        step(1'b0, 1'b1, 1'b0, OP_SUB,  1'b1, E_T3_AS,  16'd2, "sub_t3");
        step(1'b0, 1'b1, 1'b0, OP_SUB,  1'b1, E_T4_SUB, 16'd2, "sub_t4");
        step(1'b0, 1'b1, 1'b0, OP_SUB,  1'b1, E_T5,     16'd2, "sub_t5");
        step(1'b0, 1'b1, 1'b0, OP_HALT, 1'b1, E_T0,     16'd3, "halt_t0");
        step(1'b0, 1'b1, 1'b0, OP_HALT, 1'b1, E_T1,     16'd3, "halt_t1");
        step(1'b0, 1'b1, 1'b0, OP_HALT, 1'b1, E_T2,     16'd3, "halt_t2");
        step(1'b0, 1'b1, 1'b0, OP_HALT, 1'b1, E_T3_NOP, 16'd3, "halt_t3");
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 1'b0, OP_NOP, 1'b1, E_ZERO, 16'd4, "halted");
        end
        // Stop ignored in T2, illegal opcode, Stop honoured at MFLO end
        step(1'b1, 1'b1, 1'b0, OP_MFLO, 1'b1, E_ZERO,   16'd4, "clear_from_halt");
        step(1'b0, 1'b1, 1'b0, OP_MFLO, 1'b1, E_ZERO,   16'd0, "reset2");
        step(1'b0, 1'b1, 1'b0, OP_MFLO, 1'b1, E_T0,     16'd0, "mflo_t0");
        step(1'b0, 1'b1, 1'b0, OP_MFLO, 1'b1, E_T1,     16'd0, "mflo_t1");
        step(1'b0, 1'b1, 1'b1, OP_MFLO, 1'b1, E_T2,     16'd0, "mflo_t2_stop");
        step(1'b0, 1'b1, 1'b0, OP_MFLO, 1'b1, E_T3_LO,  16'd0, "mflo_t3");
        step(1'b0, 1'b1, 1'b0, OP_BAD,  1'b1, E_T0,     16'd1, "ill_t0");
        step(1'b0, 1'b1, 1'b0, OP_BAD,  1'b1, E_T1,     16'd1, "ill_t1");
        step(1'b0, 1'b1, 1'b0, OP_BAD,  1'b1, E_T2,     16'd1, "ill_t2");
        step(1'b0, 1'b1, 1'b0, OP_BAD,  1'b1, E_T3_ILL, 16'd1, "ill_t3");
        step(1'b0, 1'b1, 1'b0, OP_MFLO, 1'b1, E_T0,     16'd2, "mflo2_t0");
        step(1'b0, 1'b1, 1'b0, OP_MFLO, 1'b1, E_T1,     16'd2, "mflo2_t1");
        step(1'b0, 1'b1, 1'b0, OP_MFLO, 1'b1, E_T2,     16'd2, "mflo2_t2");
        step(1'b0, 1'b1, 1'b1, OP_MFLO, 1'b1, E_T3_LO,  16'd2, "mflo2_t3_stop");
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, OP_MFLO, 1'b1, E_ZERO, 16'd3, "stop_halted");
        end
        // Clear in the middle of an ADD execute
        step(1'b1, 1'b1, 1'b0, OP_NOP,  1'b1, E_ZERO,   16'd3, "clear_again");
        step(1'b0, 1'b1, 1'b0, OP_NOP,  1'b1, E_ZERO,   16'd0, "reset3");
        step(1'b0, 1'b1, 1'b0, OP_NOP,  1'b1, E_T0,     16'd0, "nop_t0");
        step(1'b0, 1'b1, 1'b0, OP_NOP,  1'b1, E_T1,     16'd0, "nop_t1");
        step(1'b0, 1'b1, 1'b0, OP_NOP,  1'b1, E_T2,     16'd0, "nop_t2");
        step(1'b0, 1'b1, 1'b0, OP_NOP,  1'b1, E_T3_NOP, 16'd0, "nop_t3");
        step(1'b0, 1'b1, 1'b0, OP_ADD,  1'b1, E_T0,     16'd1, "add2_t0");
        step(1'b0, 1'b1, 1'b0, OP_ADD,  1'b1, E_T1,     16'd1, "add2_t1");
        step(1'b0, 1'b1, 1'b0, OP_ADD,  1'b1, E_T2,     16'd1, "add2_t2");
        step(1'b0, 1'b1, 1'b0, OP_ADD,  1'b1, E_T3_AS,  16'd1, "add2_t3");
        step(1'b1, 1'b1, 1'b0, OP_ADD,  1'b1, E_T4_ADD, 16'd1, "add2_t4_clear");
        step(1'b0, 1'b1, 1'b0, OP_ADD,  1'b1, E_ZERO,   16'd0, "reset_midop");
        step(1'b0, 1'b0, 1'b0, OP_NOP,  1'b1, E_T0,     16'd0, "wrap_t0");
        // Counter wrap: preload 0xFFFF while parked in T1
        force dut.instr_count_q = 16'hFFFF;
        step(1'b0, 1'b0, 1'b0, OP_NOP,  1'b1, E_T1,     16'hFFFF, "wrap_t1_w");
        release dut.instr_count_q;
        step(1'b0, 1'b1, 1'b0, OP_NOP,  1'b1, E_T1,     16'hFFFF, "wrap_t1");
        step(1'b0, 1'b1, 1'b0, OP_NOP,  1'b1, E_T2,     16'hFFFF, "wrap_t2");
        step(1'b0, 1'b1, 1'b0, OP_NOP,  1'b1, E_T3_NOP, 16'hFFFF, "wrap_t3");
        step(1'b0, 1'b1, 1'b0, OP_NOP,  1'b1, E_T0,     16'h0000, "wrap_done");
        step(1'b0, 1'b1, 1'b0, OP_NOP,  1'b1, E_T1,     16'h0000, "wrap_next");
        done = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
        end
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
